uart_rx_param: RTL

UART_RX_PARAM -- requirements
Module: uart_rx_param

---
 rtl/uart_rx_param.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: 5-9 data bits, optional parity, 1-2 stop bits,
// break and frame detection, one-word holding register with overrun flag.
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset,
  input  logic                 i_RX_Serial,
  input  logic                 i_RX_Ready,
  output logic                 o_RX_Valid,
  output logic [DATA_BITS-1:0] o_RX_Data,
  output logic                 o_Parity_Err,
  output logic                 o_Frame_Err,
  output logic                 o_Break,
  output logic                 o_Overrun,
  output logic [2:0]           o_SM_State
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF    = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [3:0]    LAST_D  = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_S  = 4'(STOP_BITS - 1);
  localparam logic          ODD     = 1'(PARITY_MODE == 2);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_WAIT   = 3'd5
  } state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 zero_q, zero_d;
  logic                 brk_q, brk_d;
  logic                 meta_q, rx_q;
  logic                 tick, done;

  logic                 valid_q, ovr_q;
  logic [DATA_BITS-1:0] data_q;
  logic                 hpe_q, hfe_q, hbk_q;

  assign tick = (cnt_q == CNT_MAX);

  // Two-flop synchroniser for the asynchronous serial line
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      meta_q <= 1'b1;
      rx_q   <= 1'b1;
    end else begin
      meta_q <= i_RX_Serial;
      rx_q   <= meta_q;
    end
  end

  // Frame FSM and bit-timing registers
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      zero_q  <= 1'b1;
      brk_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      zero_q  <= zero_d;
      brk_q   <= brk_d;
    end
  end

  // Next-state logic; error flags use this cycle's sample so the
  // completing stop bit is included in what the holding register loads
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    zero_d  = zero_q;
    brk_d   = brk_q;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        idx_d  = '0;
        perr_d = 1'b0;
        ferr_d = 1'b0;
        zero_d = 1'b1;
        brk_d  = 1'b0;
        if (!rx_q) state_d = S_START;
      end
      S_START: begin
        if (cnt_q == HALF) begin
          cnt_d   = '0;
          state_d = rx_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (tick) begin
          cnt_d   = '0;
          shift_d = {rx_q, shift_q[DATA_BITS-1:1]};
          zero_d  = zero_q & ~rx_q;
          if (idx_q == LAST_D) begin
            idx_d   = '0;
            state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (tick) begin
          cnt_d   = '0;
          zero_d  = zero_q & ~rx_q;
          perr_d  = ((^shift_q) ^ rx_q) != ODD;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (tick) begin
          cnt_d  = '0;
          ferr_d = ferr_q | ~rx_q;
          if (idx_q == 4'd0) brk_d = zero_q & ~rx_q;
          if (idx_q == LAST_S) begin
            done    = 1'b1;
            idx_d   = '0;
            state_d = rx_q ? S_IDLE : S_WAIT;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WAIT: begin
        if (rx_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Holding register: load on completion if empty or being read,
  // otherwise drop the frame and flag overrun
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      data_q  <= '0;
      hpe_q   <= 1'b0;
      hfe_q   <= 1'b0;
      hbk_q   <= 1'b0;
    end else if (done && (!valid_q || i_RX_Ready)) begin
      valid_q <= 1'b1;
      data_q  <= shift_q;
      hpe_q   <= perr_q;
      hfe_q   <= ferr_d;
      hbk_q   <= brk_d;
    end else if (done) begin
      ovr_q <= 1'b1;
    end else if (valid_q && i_RX_Ready) begin
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end
  end

  assign o_RX_Valid   = valid_q;
  assign o_RX_Data    = data_q;
  assign o_Parity_Err = hpe_q;
  assign o_Frame_Err  = hfe_q;
  assign o_Break      = hbk_q;
  assign o_Overrun    = ovr_q;
  assign o_SM_State   = state_q;

endmodule
